// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared definitions for the pipeline stall/flush controller.
//   - stall bus width and Stop/NoStop levels
//   - reset polarity, register bus width, zero word
//   - stall patterns (one per requesting stage, plus none/all)
//   - controller FSM state encoding
//   - encode_stall(): priority encoder, highest stage wins
package pipeline_ctrl_pkg;

  localparam int unsigned STALL_W    = 6;
  localparam int unsigned REG_W      = 32;

  localparam logic        STOP       = 1'b1;
  localparam logic        NO_STOP    = 1'b0;
  localparam logic        RST_ENABLE = 1'b1;

  localparam logic [REG_W-1:0]   ZERO_WORD = '0;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_FLUSH   = 2'd2
  } ctrl_state_e;

  function automatic logic [STALL_W-1:0] encode_stall(
    input logic req_mem,
    input logic req_ex,
    input logic req_id,
    input logic req_if
  );
    logic [STALL_W-1:0] pat;
    pat = STALL_NONE;
    if (req_mem)     pat = STALL_MEM;
    else if (req_ex) pat = STALL_EX;
    else if (req_id) pat = STALL_ID;
    else if (req_if) pat = STALL_IF;
    return pat;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_mc_timer.sv
// ctrl_mc_timer: load/decrement counter that times a multi-cycle EX op.
//   clk, rst   : clock, synchronous active-high reset
//   load       : load load_val (takes precedence over decrement)
//   load_val   : remaining cycles after the start cycle (N-1)
//   clear      : abort, counter to zero (takes precedence over load)
//   busy_o     : more than one cycle left (EX must keep stalling)
//   done_o     : final cycle of the op (result valid)
module ctrl_mc_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clear,
  output logic             busy_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign busy_o = (cnt_q > CNT_W'(1));
  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush controller for the six-stage pipeline.
//   clk, rst         : clock, synchronous active-high reset
//   stallreq_*_i     : stage stall requests (if, id, ex, mem)
//   mc_start_i       : first cycle of a multi-cycle EX op
//   mc_cycles_i      : total EX cycles N of that op
//   flush_req_i      : exception commit request from MEM
//   flush_pc_i       : redirect PC captured with the request
//   stall_o          : stall bus, bit0 PC .. bit5 WB, 1 = Stop
//   mc_done_o        : EX multi-cycle result valid this cycle
//   flush_o          : one-cycle clear of all stage registers
//   new_pc_o         : PC to load while flush_o is high
//   stall_timeout_o  : sticky lock-up flag (MAX_STALL stalled cycles)
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MAX_STALL = 1023,
  parameter int unsigned CNT_W     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if_i,
  input  logic               stallreq_id_i,
  input  logic               stallreq_ex_i,
  input  logic               stallreq_mem_i,
  input  logic               mc_start_i,
  input  logic [CNT_W-1:0]   mc_cycles_i,
  input  logic               flush_req_i,
  input  logic [REG_W-1:0]   flush_pc_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               mc_done_o,
  output logic               flush_o,
  output logic [REG_W-1:0]   new_pc_o,
  output logic               stall_timeout_o
);

  localparam int unsigned    WD_W   = $clog2(MAX_STALL + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL);

  ctrl_state_e      state_q, state_d;
  logic             mc_long;
  logic             mc_stall, mc_done_c;
  logic             tmr_load, tmr_clear, tmr_busy, tmr_done;
  logic             capture;
  logic [REG_W-1:0] new_pc_q;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             timeout_q;
  logic             stall_any;

  assign mc_long = mc_start_i && (mc_cycles_i >= CNT_W'(2));

  ctrl_mc_timer #(.CNT_W(CNT_W)) u_mc_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (mc_cycles_i - CNT_W'(1)),
    .clear    (tmr_clear),
    .busy_o   (tmr_busy),
    .done_o   (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state_q <= ST_IDLE;
    else                   state_q <= state_d;
  end

  // The start cycle is visible combinationally (stall or one-cycle done)
  // even when a simultaneous flush discards the op.
  always_comb begin
    state_d   = state_q;
    mc_stall  = 1'b0;
    mc_done_c = 1'b0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mc_stall  = mc_long;
        mc_done_c = mc_start_i && !mc_long;
        if (flush_req_i) begin
          capture = 1'b1;
          state_d = ST_FLUSH;
        end else if (mc_long) begin
          tmr_load = 1'b1;
          state_d  = ST_MC_BUSY;
        end
      end
      ST_MC_BUSY: begin
        mc_stall  = tmr_busy;
        mc_done_c = tmr_done;
        if (flush_req_i) begin
          capture   = 1'b1;
          tmr_clear = 1'b1;
          state_d   = ST_FLUSH;
        end else if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    stall_o = STALL_NONE;
    if ((rst != RST_ENABLE) && (state_q != ST_FLUSH)) begin
      stall_o = encode_stall(stallreq_mem_i, stallreq_ex_i || mc_stall,
                             stallreq_id_i, stallreq_if_i);
    end
  end

  assign mc_done_o = mc_done_c && (rst != RST_ENABLE);
  assign flush_o   = (state_q == ST_FLUSH);
  assign new_pc_o  = new_pc_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) new_pc_q <= ZERO_WORD;
    else if (capture)      new_pc_q <= flush_pc_i;
  end

  // Every non-empty stall pattern stops the PC, so bit0 flags "stalled".
  assign stall_any = (stall_o[0] == STOP);

  always_comb begin
    wd_d = '0;
    if (stall_any && !flush_o) begin
      wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_q || (wd_d == WD_MAX);
    end
  end

  assign stall_timeout_o = timeout_q;

endmodule
